// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM between the MiniMIPS32 instruction
// fetch port (I) and data port (D). One requester is granted per cycle and the
// 1-cycle SRAM read latency is pipelined through an owner register, so
// back-to-back accesses run at one access per cycle.
//
// Arbitration: D wins a conflict unless I has been denied MAX_WAIT consecutive
// cycles, in which case I is forced through.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_req/i_addr       fetch request and address
//   i_gnt              fetch issued to SRAM this cycle
//   i_rvalid/i_rdata   fetch response, one cycle after i_gnt
//   d_req/d_wen/d_addr/d_wdata  data request (d_wen == 0000 is a read)
//   d_gnt              data request issued this cycle
//   d_rvalid/d_rdata   load response, one cycle after a read d_gnt
//   stall_o            some requester is asserting req without a grant
//   mem_en/mem_wen/mem_addr/mem_wdata  SRAM command, driven from the grant
//   mem_rdata          SRAM read data, valid the cycle after mem_en
//
// Optional build macro ARB_PERF_CNT_EN adds perf_conflict / perf_forced
// counters (cycles with both requests; cycles I won by wait override).

module sram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_o,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_forced,
`endif
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [1:0]        owner;
  logic              owner_write;
  logic [3:0]        wait_cnt;
  logic              forced;
  logic [DATA_W-1:0] i_hold;
  logic [DATA_W-1:0] d_hold;

  // I is forced only when it has starved long enough and D is competing;
  // without a conflict the lone requester simply wins.
  assign forced = i_req & d_req & (wait_cnt == MAX_WAIT_C);
  assign i_gnt  = ~rst & i_req & (~d_req | forced);
  assign d_gnt  = ~rst & d_req & ~forced;

  // Gated by rst so every output sits at its reset value while reset is held.
  assign stall_o = ~rst & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_wen   = d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Owner of the access now in the SRAM pipeline; clearing it on reset
  // drops any response that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      owner_write <= 1'b0;
    end else if (i_gnt) begin
      owner       <= OWN_I;
      owner_write <= 1'b0;
    end else if (d_gnt) begin
      owner       <= OWN_D;
      owner_write <= (d_wen != 4'b0000);
    end else begin
      owner       <= OWN_NONE;
      owner_write <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (i_req & ~i_gnt) begin
      if (wait_cnt != MAX_WAIT_C) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  assign i_rvalid = ~rst & (owner == OWN_I);
  assign d_rvalid = ~rst & (owner == OWN_D) & ~owner_write;

  // Response data passes straight through while valid and otherwise shows
  // the last delivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (i_rvalid) i_hold <= mem_rdata;
      if (d_rvalid) d_hold <= mem_rdata;
    end
  end

  assign i_rdata = rst ? '0 : (i_rvalid ? mem_rdata : i_hold);
  assign d_rdata = rst ? '0 : (d_rvalid ? mem_rdata : d_hold);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict <= 32'd0;
      perf_forced   <= 32'd0;
    end else begin
      if (i_req & d_req) perf_conflict <= perf_conflict + 32'd1;
      if (forced)        perf_forced   <= perf_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// single-port synchronous SRAM (byte writes, 1-cycle read latency).

module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [3:0]  d_wen = 4'b0000;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        stall_o;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict, perf_forced;
`endif

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .stall_o(stall_o),
`ifdef ARB_PERF_CNT_EN
    .perf_conflict(perf_conflict), .perf_forced(perf_forced),
`endif
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten words come from init_word.
  bit [31:0] sram [bit [31:0]];
  logic [31:0] wword;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h2402_000A;
    if (a >= 32'h0000_2000) return 32'h0;
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a);
    if (sram.exists(a)) return sram[a];
    return init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen == 4'b0000) begin
        mem_rdata <= read_word(mem_addr);
      end else begin
        wword = read_word(mem_addr);
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) wword[b*8 +: 8] = mem_wdata[b*8 +: 8];
        sram[mem_addr] = wword;
      end
    end
  end

  // Advance to just after the next rising edge; new inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h80;
    d_wen = 4'b1111; d_wdata = 32'h1234_5678;
    tick(); tick();
    #3;
    checks++; if ({i_gnt, d_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 00", {i_gnt, d_gnt}); end
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 00", {i_rvalid, d_rvalid}); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", stall_o); end
    checks++; if ({mem_en, mem_wen} !== 5'b0) begin errors++; $display("[TB] FAIL reset_mem_ctl: got %b want 00000", {mem_en, mem_wen}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata}); end
    i_req = 1'b0; d_req = 1'b0; d_wen = 4'b0000; d_wdata = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h1000;
    #3;
    checks++; if ({i_gnt, d_gnt, mem_en} !== 3'b101) begin errors++; $display("[TB] FAIL fetch_gnt: got %b want 101", {i_gnt, d_gnt, mem_en}); end
    checks++; if (mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL fetch_addr: got %h want 00001000", mem_addr); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall: got %b want 0", stall_o); end
    tick();
    i_req = 1'b0;
    #3;
    checks++; if (i_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_rvalid: got %b want 1", i_rvalid); end
    checks++; if (i_rdata !== 32'h2402_000A) begin errors++; $display("[TB] FAIL fetch_rdata: got %h want 2402000a", i_rdata); end
    tick();
    #3;
    checks++; if (i_rvalid !== 1'b0 || i_rdata !== 32'h2402_000A) begin errors++; $display("[TB] FAIL fetch_hold: got rvalid %b data %h want 0 2402000a", i_rvalid, i_rdata); end
  endtask

  task automatic test_conflict();
    tick();
    i_req = 1'b1; i_addr = 32'h1004;
    d_req = 1'b1; d_addr = 32'h0800; d_wen = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      #3;
      if (c < 4) begin
        checks++; if ({i_gnt, d_gnt} !== 2'b01) begin errors++; $display("[TB] FAIL conflict_d_win%0d: got %b want 01", c, {i_gnt, d_gnt}); end
      end else begin
        checks++; if ({i_gnt, d_gnt} !== 2'b10) begin errors++; $display("[TB] FAIL conflict_forced: got %b want 10", {i_gnt, d_gnt}); end
      end
      checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL conflict_stall%0d: got %b want 1", c, stall_o); end
      if (c > 0) begin
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE_0800) begin errors++; $display("[TB] FAIL conflict_dresp%0d: got %b %h want 1 c0de0800", c, d_rvalid, d_rdata); end
      end
      tick();
    end
    #3;
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hC0DE_1004) begin errors++; $display("[TB] FAIL conflict_iresp: got %b %h want 1 c0de1004", i_rvalid, i_rdata); end
    checks++; if ({i_gnt, d_gnt} !== 2'b01) begin errors++; $display("[TB] FAIL conflict_wait_clear: got %b want 01", {i_gnt, d_gnt}); end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    tick();
    d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    #3;
    checks++; if ({d_gnt, mem_en, mem_wen} !== 6'b110011) begin errors++; $display("[TB] FAIL store_cmd: got %b want 110011", {d_gnt, mem_en, mem_wen}); end
    checks++; if (mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store_bus: got %h %h want 00002000 deadbeef", mem_addr, mem_wdata); end
    tick();
    d_wen = 4'b0000;
    #3;
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL store_no_rvalid: got %b want 0", d_rvalid); end
    checks++; if (d_gnt !== 1'b1 || mem_wen !== 4'b0000) begin errors++; $display("[TB] FAIL load_cmd: got %b %b want 1 0000", d_gnt, mem_wen); end
    tick();
    d_req = 1'b0;
    #3;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL load_data: got %b %h want 1 0000beef", d_rvalid, d_rdata); end
    // A fetch from the stored address sees the written contents.
    tick();
    i_req = 1'b1; i_addr = 32'h2000;
    tick();
    i_req = 1'b0;
    #3;
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL store_fetch: got %b %h want 1 0000beef", i_rvalid, i_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_addr;
    logic        prev_i;
    prev_addr = '0; prev_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        i_req = (k % 2 == 0); d_req = (k % 2 == 1); d_wen = 4'b0000;
        i_addr = 32'h100 + 32'(4 * k); d_addr = 32'h200 + 32'(4 * k);
      end else begin
        i_req = 1'b0; d_req = 1'b0;
      end
      #3;
      if (k < 6) begin
        checks++; if ({i_gnt, d_gnt} !== {i_req, d_req}) begin errors++; $display("[TB] FAIL b2b_gnt%0d: got %b want %b", k, {i_gnt, d_gnt}, {i_req, d_req}); end
      end
      if (k > 0) begin
        checks++; if ({i_rvalid, d_rvalid} !== {prev_i, ~prev_i}) begin errors++; $display("[TB] FAIL b2b_rvalid%0d: got %b want %b", k, {i_rvalid, d_rvalid}, {prev_i, ~prev_i}); end
        checks++;
        if ((prev_i ? i_rdata : d_rdata) !== init_word(prev_addr)) begin
          errors++; $display("[TB] FAIL b2b_data%0d: got %h want %h", k, (prev_i ? i_rdata : d_rdata), init_word(prev_addr));
        end
      end
      prev_i = i_req; prev_addr = i_req ? i_addr : d_addr;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = 32'h1000;
    #3;
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("[TB] FAIL mid_gnt: got %b want 1", i_gnt); end
    tick();
    rst = 1'b1; i_req = 1'b0;
    #3;
    checks++; if ({i_rvalid, d_rvalid, stall_o, mem_en} !== 4'b0) begin errors++; $display("[TB] FAIL mid_rst_ctl: got %b want 0000", {i_rvalid, d_rvalid, stall_o, mem_en}); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("[TB] FAIL mid_rst_data: got %h want 0", {i_rdata, d_rdata}); end
    tick();
    rst = 1'b0;
    #3;
    checks++; if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_after: got %b %h want 0 0", i_rvalid, i_rdata); end
    tick();
    i_req = 1'b1; i_addr = 32'h0104;
    #3;
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("[TB] FAIL mid_next_gnt: got %b want 1", i_gnt); end
    tick();
    i_req = 1'b0;
    #3;
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hC0DE_0104) begin errors++; $display("[TB] FAIL mid_next_data: got %b %h want 1 c0de0104", i_rvalid, i_rdata); end
    tick();
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h1000; d_addr = 32'h0800; d_wen = 4'b0000;
    for (int c = 0; c < 10; c++) tick();
    i_req = 1'b0; d_req = 1'b0;
    #3;
    checks++; if (perf_conflict !== 32'd10) begin errors++; $display("[TB] FAIL perf_conflict: got %0d want 10", perf_conflict); end
    checks++; if (perf_forced !== 32'd2) begin errors++; $display("[TB] FAIL perf_forced: got %0d want 2", perf_forced); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_store_load();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
